mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Word-addressed memory that answers the datapath's MAR/MDR memory requests.
//  It captures an address, an op (read/write) and write data, then applies
//  WAIT_STATES stall cycles. It completes the access and pulses mem_ready.
//  Read data is returned on Mdatain; the datapath's MDR latches it when MD_read is high.
// PARAMETERS
//  DATA_W       32   word width; matches the bus
//  ADDR_W       9    address width; DEPTH = 2**ADDR_W words (512)
//  WAIT_STATES  2    stall cycles between request capture and access (0..15)
// PORTS
//  clock      in   1       single clock; all state changes on its rising edge
//  clear      in   1       asynchronous, active-high reset
//  mem_read   in   1       read request strobe; sampled only in IDLE
//  mem_write  in   1       write request strobe; sampled only in IDLE
//  address    in   ADDR_W  word address (driven from MAR low bits)
//  data_in    in   DATA_W  write data (driven from MDR output)
//  Mdatain    out  DATA_W  registered read data, to the MDR input mux
//  mem_ready  out  1       one-cycle pulse: access complete
//  mem_busy   out  1       high whenever FSM != IDLE
//  addr_err   out  1       only with MEM_BOUNDS_CHECK_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (clear=1, async): FSM=IDLE, wait counter=0, Mdatain=0, mem_ready=0,
//   mem_busy=0, addr_err=0. The RAM array is NOT cleared; contents persist.
//  FSM states: IDLE -> WAIT -> ACCESS -> IDLE.
//  IDLE: on an edge with mem_write=1, capture address, data_in and op=WR.
//   Otherwise, on an edge with mem_read=1, capture address and op=RD.
//   After either capture, counter=WAIT_STATES. Go to WAIT, or straight to
//   ACCESS if WAIT_STATES=0.
//  - Simultaneous mem_read & mem_write: the write wins; the read is dropped.
//  - With no strobe high, stay in IDLE.
//  WAIT: decrement the counter each edge; go to ACCESS on the edge where it
//   reaches 0. Strobes, address and data_in are ignored here.
//  ACCESS (one cycle): perform the op on the captured address, using the
//   captured data. On the exiting edge, set mem_ready=1 for exactly one cycle
//   and return to IDLE.
//  - WR: array[addr] <= captured data; Mdatain unchanged.
//  - RD: Mdatain <= array[addr]; Mdatain holds until the next completed read.
//  Latency: for a request captured at edge N, the access occurs at edge
//   N+WAIT_STATES+1. mem_ready is high for the cycle following that edge.
//   The earliest next capture is the edge ending the mem_ready cycle,
//   provided a strobe is high then.
//  Back-to-back: a strobe held high re-triggers a new access as soon as the
//   FSM is back in IDLE (level-sampled, not edge-detected).
//  Read-after-write to the same address returns the newly written word.
//  Address wrap: none needed; ADDR_W bits fully index DEPTH.
//  Reset mid-operation: the in-flight access is abandoned. A write that has
//   not reached ACCESS does not modify the array. mem_ready never pulses.
// CONFIGURATION
//  MEM_BOUNDS_CHECK_EN defined:
//  - Adds parameter LIMIT (default 256) and output addr_err.
//  - A captured address >= LIMIT completes normally in timing: mem_ready
//    pulses as usual.
//  - The array is not written, Mdatain is set to 0, and addr_err=1 for the
//    mem_ready cycle only.
//  MEM_BOUNDS_CHECK_EN undefined: no addr_err port; every address is valid.
// TESTING
//  1 Reset: assert clear mid-cycle -> Mdatain=0, mem_ready=0, mem_busy=0
//    immediately, with no clock edge required.
//  2 Write 0xDEADBEEF @0x012, then read @0x012 -> Mdatain=0xDEADBEEF. With
//    WAIT_STATES=2, mem_ready is seen 3 edges after each capture.
//  3 Simultaneous read+write @0x005, data 0x0000_00A5 -> write performed and
//    Mdatain unchanged; a later read @0x005 returns 0x000000A5.
//  4 Strobes toggled during WAIT (new addr 0x1FF) -> ignored; the access uses
//    the originally captured address. mem_busy stays 1 until the ready cycle.
//  5 Write 0x11111111 @0x020, assert clear during WAIT, then read @0x020 ->
//    returns the prior contents (not 0x11111111); no mem_ready pulse.
//  6 MEM_BOUNDS_CHECK_EN, LIMIT=256: write 0xCAFE @0x100 -> addr_err=1 with
//    mem_ready. A following read @0x100 -> Mdatain=0 and addr_err=1.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between the datapath (master) and mem_responder (slave).
// addr_err exists only when MEM_BOUNDS_CHECK_EN is defined.
interface mem_responder_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] Mdatain;
  logic              mem_ready;
  logic              mem_busy;
`ifdef MEM_BOUNDS_CHECK_EN
  logic              addr_err;
`endif

  modport master (
    output mem_read, mem_write, address, data_in,
    input  Mdatain, mem_ready, mem_busy
`ifdef MEM_BOUNDS_CHECK_EN
    , input addr_err
`endif
  );

  modport slave (
    input  mem_read, mem_write, address, data_in,
    output Mdatain, mem_ready, mem_busy
`ifdef MEM_BOUNDS_CHECK_EN
    , output addr_err
`endif
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM with a fixed number of wait states per request.
// Optional MEM_BOUNDS_CHECK_EN adds LIMIT and addr_err for out-of-range accesses.
module mem_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
`ifdef MEM_BOUNDS_CHECK_EN
  , parameter int LIMIT     = 256
`endif
) (
  input  logic              clock,
  input  logic              clear,
  mem_responder_if.slave    bus
);

  localparam int         DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_op_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_ready;
  logic              r_busy;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_oob;
  logic              w_wr_en;

`ifdef MEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_W:0] LIMIT_W = (ADDR_W + 1)'(LIMIT);
  logic r_err;
  assign w_oob        = ({1'b0, r_addr} >= LIMIT_W);
  assign bus.addr_err = r_err;
`else
  assign w_oob = 1'b0;
`endif

  // The array has no reset so its contents survive clear; clear also blocks a
  // write on an edge that coincides with reset assertion.
  assign w_wr_en = (r_state == S_ACCESS) && r_op_wr && !w_oob && !clear;

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[r_addr] <= r_wdata;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op_wr <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_ready <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
      r_err   <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          // Write has priority; a simultaneous read is dropped.
          if (bus.mem_write || bus.mem_read) begin
            r_addr  <= bus.address;
            r_op_wr <= bus.mem_write;
            if (bus.mem_write) r_wdata <= bus.data_in;
            r_cnt   <= WS;
            r_busy  <= 1'b1;
            r_state <= (WS == 4'd0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_oob)         r_rdata <= '0;
          else if (!r_op_wr) r_rdata <= r_mem[r_addr];
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
`ifdef MEM_BOUNDS_CHECK_EN
          r_err   <= w_oob;
`endif
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.Mdatain   = r_rdata;
  assign bus.mem_ready = r_ready;
  assign bus.mem_busy  = r_busy;

endmodule
